// File: rtl/demux_stage_64.sv
// demux_stage_64: one-in, two-out steering stage for datapath words.
//
// A word arriving on the input valid/ready channel is routed by in_sel into one of
// two per-destination FIFOs. Each FIFO head is presented on its own output channel.
// The two consumers stall independently of each other.
//
// Storage is fully registered, so there is no fall-through path. A word pushed into an
// empty FIFO at edge N is visible on that channel from edge N onward.
//
// in_ready depends only on in_sel and the registered occupancy. It never depends on
// zero_ready or one_ready, so a full FIFO refuses a push even in a cycle where it pops.
//
// Optional feature (compile-time macro DEMUX_STATS_EN):
//   When DEMUX_STATS_EN is defined, the CNT_W parameter and the zero_count/one_count
//   ports exist. Each counter counts words delivered on its channel and wraps at
//   2^CNT_W - 1 -> 0. When the macro is undefined, the parameter, the ports and their
//   logic are all absent.
//
// Parameters:
//   WIDTH  data word width
//   DEPTH  entries per output FIFO (power of 2, >= 2)
//   CNT_W  transfer counter width (DEMUX_STATS_EN only)
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   in_valid, in_ready, in_sel,     input channel; in_sel 0 -> zero channel, 1 -> one channel
//   in_data
//   zero_valid, zero_ready,         zero output channel (head of the zero FIFO)
//   zero_data
//   one_valid, one_ready, one_data  one output channel (head of the one FIFO)
//   zero_count, one_count           delivered-word counters (DEMUX_STATS_EN only)

module demux_stage_64 #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
`ifdef DEMUX_STATS_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             zero_valid,
    input  logic             zero_ready,
    output logic [WIDTH-1:0] zero_data,
    output logic             one_valid,
    input  logic             one_ready,
    output logic [WIDTH-1:0] one_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] zero_count,
    output logic [CNT_W-1:0] one_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    // Index 0 is the zero channel, index 1 is the one channel.
    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];
    logic [OCC_W-1:0] occ_q    [2];
    logic [OCC_W-1:0] occ_d    [2];

    logic [1:0] full;
    logic [1:0] not_empty;
    logic [1:0] out_ready;
    logic [1:0] push;
    logic [1:0] pop;

    // Handshake decode
    always_comb begin
        out_ready = {one_ready, zero_ready};
        for (int c = 0; c < 2; c++) begin
            full[c]      = (occ_q[c] == OCC_W'(DEPTH));
            not_empty[c] = (occ_q[c] != '0);
        end
        // Readiness is judged only against the addressed FIFO.
        in_ready = ~full[in_sel];
        push[0]  = in_valid & ~in_sel & ~full[0];
        push[1]  = in_valid &  in_sel & ~full[1];
        // Pop requires a non-empty FIFO, so occupancy cannot underflow.
        pop      = not_empty & out_ready;
    end

    // Pointer and occupancy next state
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            occ_d[c]    = occ_q[c];
            if (push[c]) begin
                // DEPTH is a power of two, so the pointer wraps DEPTH-1 -> 0 by overflow.
                wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(1);
            end
            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
            end
            // Push and pop together leave the occupancy unchanged.
            if (push[c] && !pop[c]) begin
                occ_d[c] = occ_q[c] + OCC_W'(1);
            end else if (!push[c] && pop[c]) begin
                occ_d[c] = occ_q[c] - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                occ_q[c]    <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[c][i] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                occ_q[c]    <= occ_d[c];
                if (push[c]) begin
                    mem_q[c][wr_ptr_q[c]] <= in_data;
                end
            end
        end
    end

    // Output channels present the registered FIFO heads directly. There is no bypass.
    always_comb begin
        zero_valid = not_empty[0];
        zero_data  = mem_q[0][rd_ptr_q[0]];
        one_valid  = not_empty[1];
        one_data   = mem_q[1][rd_ptr_q[1]];
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] zero_count_q;
    logic [CNT_W-1:0] one_count_q;

    // Counters wrap naturally at 2^CNT_W - 1 -> 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_count_q <= '0;
            one_count_q  <= '0;
        end else begin
            if (pop[0]) begin
                zero_count_q <= zero_count_q + CNT_W'(1);
            end
            if (pop[1]) begin
                one_count_q <= one_count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        zero_count = zero_count_q;
        one_count  = one_count_q;
    end
`endif

endmodule

// File: tb/tb_demux_stage_64.sv
module tb_demux_stage_64;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [63:0] in_data;
    logic        zero_valid;
    logic        zero_ready;
    logic [63:0] zero_data;
    logic        one_valid;
    logic        one_ready;
    logic [63:0] one_data;
`ifdef DEMUX_STATS_EN
    logic [31:0] zero_count;
    logic [31:0] one_count;
`endif

    int n_checks;
    int n_fail;

    demux_stage_64 dut (
`ifdef DEMUX_STATS_EN
        .zero_count (zero_count),
        .one_count  (one_count),
`endif
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .zero_valid (zero_valid),
        .zero_ready (zero_ready),
        .zero_data  (zero_data),
        .one_valid  (one_valid),
        .one_ready  (one_ready),
        .one_data   (one_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at posedge+1, and outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic        sel;
        logic [63:0] d;
        logic        zr;
        logic        orr;
        logic        rdy;   // expected in_ready before the edge
        logic        zv;    // expected outputs after the edge
        logic [63:0] zd;
        logic        ov;
        logic [63:0] od;
    } vec_t;

    function automatic vec_t mk(logic v, logic sel, logic [63:0] d, logic zr, logic orr,
                                logic rdy, logic zv, logic [63:0] zd, logic ov,
                                logic [63:0] od);
        vec_t r;
        r.v = v; r.sel = sel; r.d = d; r.zr = zr; r.orr = orr;
        r.rdy = rdy; r.zv = zv; r.zd = zd; r.ov = ov; r.od = od;
        return r;
    endfunction

    localparam logic [63:0] WA = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] WB = 64'h5555_0000_0000_0002;

    vec_t vecs[14];

    logic [63:0] zq[$];
    logic [63:0] oq[$];

    initial begin
        int idx;
        int zdel;
        int odel;
        int cyc;
        logic exp_rdy;
        logic do_push;
        logic zpop;
        logic opop;

        n_checks = 0;
        n_fail   = 0;

        // Steering, backpressure, full+pop, push/pop on the same FIFO
        vecs[0]  = mk(1, 0, WA,       1, 1, 1, 1, WA,     0, 64'h0);
        vecs[1]  = mk(1, 1, WB,       1, 1, 1, 0, 64'h0,  1, WB);
        vecs[2]  = mk(0, 0, 64'h0,    1, 1, 1, 0, 64'h0,  0, 64'h0);
        vecs[3]  = mk(1, 0, 64'h1,    0, 0, 1, 1, 64'h1,  0, 64'h0);
        vecs[4]  = mk(1, 0, 64'h2,    0, 0, 1, 1, 64'h1,  0, 64'h0);
        vecs[5]  = mk(1, 0, 64'h3,    0, 0, 0, 1, 64'h1,  0, 64'h0);
        vecs[6]  = mk(1, 1, 64'h10,   0, 0, 1, 1, 64'h1,  1, 64'h10);
        vecs[7]  = mk(1, 0, 64'h3,    1, 0, 0, 1, 64'h2,  1, 64'h10);
        vecs[8]  = mk(1, 0, 64'h3,    0, 0, 1, 1, 64'h2,  1, 64'h10);
        vecs[9]  = mk(0, 0, 64'h0,    1, 1, 0, 1, 64'h3,  0, WB);
        vecs[10] = mk(0, 0, 64'h0,    1, 1, 1, 0, 64'h2,  0, WB);
        vecs[11] = mk(1, 1, 64'h20,   1, 1, 1, 0, 64'h2,  1, 64'h20);
        vecs[12] = mk(1, 1, 64'h21,   1, 1, 1, 0, 64'h2,  1, 64'h21);
        vecs[13] = mk(0, 1, 64'h0,    1, 1, 1, 0, 64'h2,  0, 64'h20);

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        zero_ready = 1'b0;
        one_ready  = 1'b0;
        tick();
        tick();
        check("rst_zv", zero_valid, 0);
        check("rst_ov", one_valid, 0);
        check("rst_zd", zero_data, 0);
        check("rst_od", one_data, 0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        tick();

        foreach (vecs[i]) begin
            in_valid   = vecs[i].v;
            in_sel     = vecs[i].sel;
            in_data    = vecs[i].d;
            zero_ready = vecs[i].zr;
            one_ready  = vecs[i].orr;
            #1;
            check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].rdy);
            tick();
            check($sformatf("v%0d_zv", i), zero_valid, vecs[i].zv);
            check($sformatf("v%0d_zd", i), zero_data, vecs[i].zd);
            check($sformatf("v%0d_ov", i), one_valid, vecs[i].ov);
            check($sformatf("v%0d_od", i), one_data, vecs[i].od);
        end

        // Mid-stream reset with two words buffered in the zero FIFO
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        zero_ready = 1'b0;
        one_ready  = 1'b0;
        in_data    = 64'hDEAD_0000_0000_0001;
        tick();
        in_data    = 64'hDEAD_0000_0000_0002;
        tick();
        in_valid = 1'b0;
        check("mid_zv_before_rst", zero_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_zv", zero_valid, 0);
        check("mid_rst_ov", one_valid, 0);
        check("mid_rst_zd", zero_data, 0);
        check("mid_rst_od", one_data, 0);
        tick();
        reset_n = 1'b1;
        in_sel  = 1'b0;
        #1;
        check("mid_rel_ready0", in_ready, 1);
        in_sel = 1'b1;
        #1;
        check("mid_rel_ready1", in_ready, 1);
        tick();

        // Random-ready stream of 10 alternating words against a queue model
        idx  = 0;
        zdel = 0;
        odel = 0;
        cyc  = 0;
        while ((idx < 10 || zq.size() != 0 || oq.size() != 0) && cyc < 200) begin
            in_valid   = (idx < 10);
            in_sel     = idx[0];
            in_data    = 64'hC0DE_0000_0000_0000 | 64'(idx);
            zero_ready = 1'($urandom_range(0, 1));
            one_ready  = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = in_sel ? (oq.size() < DEPTH) : (zq.size() < DEPTH);
            check($sformatf("s%0d_in_ready", cyc), in_ready, exp_rdy);
            do_push = in_valid && exp_rdy;
            zpop    = (zq.size() != 0) && zero_ready;
            opop    = (oq.size() != 0) && one_ready;
            tick();
            if (zpop) begin
                void'(zq.pop_front());
                zdel++;
            end
            if (opop) begin
                void'(oq.pop_front());
                odel++;
            end
            if (do_push) begin
                if (in_sel) oq.push_back(in_data);
                else        zq.push_back(in_data);
                idx++;
            end
            check($sformatf("s%0d_zv", cyc), zero_valid, zq.size() != 0);
            check($sformatf("s%0d_ov", cyc), one_valid, oq.size() != 0);
            if (zq.size() != 0) check($sformatf("s%0d_zd", cyc), zero_data, zq[0]);
            if (oq.size() != 0) check($sformatf("s%0d_od", cyc), one_data, oq[0]);
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_all_pushed", 64'(idx), 64'd10);
        check("stream_zero_delivered", 64'(zdel), 64'd5);
        check("stream_one_delivered", 64'(odel), 64'd5);

`ifdef DEMUX_STATS_EN
        // Counter check: 3 zero and 5 one deliveries, then reset clears both
        reset_n = 1'b0;
        tick();
        reset_n    = 1'b1;
        zero_ready = 1'b1;
        one_ready  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_sel   = (k >= 3);
            in_data  = 64'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("cnt_zero", zero_count, 32'd3);
        check("cnt_one", one_count, 32'd5);
        reset_n = 1'b0;
        #1;
        check("cnt_zero_rst", zero_count, 32'd0);
        check("cnt_one_rst", one_count, 32'd0);
        tick();
        reset_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
